// File: rtl/aes_gcm_tag_verify_pkg.sv
// -----------------------------------------------------------------------------
// aes_gcm_pkg
// Shared types and constants for the AES-GCM tag path.
//   block_t      : 128-bit GCM block, bit 0 is the MSB (GCM bit order)
//   GCM_R        : reduction constant 0xE1 || 0^120 for the reflected field
//   gcm_vstate_e : states of the receive-side tag verifier
// -----------------------------------------------------------------------------
package aes_gcm_pkg;

  typedef logic [0:127] block_t;

  localparam block_t GCM_R = {8'hE1, 120'd0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AAD,
    ST_CT,
    ST_LEN,
    ST_CHECK
  } gcm_vstate_e;

endpackage

// File: rtl/aes_gcm_tag_verify_if.sv
// -----------------------------------------------------------------------------
// aes_gcm_tag_verify_if
// Block stream into the tag verifier (AAD blocks, then ciphertext blocks).
//   i_valid : block valid (driven by master)
//   i_block : 128-bit block, last one zero-padded by the sender
//   o_ready : verifier accepts the block when i_valid && o_ready
// Modports: master (block source), slave (verifier).
// -----------------------------------------------------------------------------
interface aes_gcm_tag_verify_if;
  import aes_gcm_pkg::*;

  logic   i_valid;
  block_t i_block;
  logic   o_ready;

  modport master (output i_valid, output i_block, input o_ready);
  modport slave  (input i_valid, input i_block, output o_ready);

endinterface

// File: rtl/aes_gcm_tag_verify_gf128_mul.sv
// -----------------------------------------------------------------------------
// gf128_mul
// Single-cycle combinational GF(2^128) multiply in GCM bit order
// (bit 0 = coefficient of x^0), polynomial x^128 + x^7 + x^2 + x + 1.
//   a, b : operands
//   p    : product a * b
// Shared with the encrypt-side tag stage.
// -----------------------------------------------------------------------------
module gf128_mul
  import aes_gcm_pkg::*;
(
  input  block_t a,
  input  block_t b,
  output block_t p
);

  block_t z_acc;
  block_t v_acc;

  // Right shift in this bit order multiplies by x; a carry out of bit 127
  // is folded back with R.
  always_comb begin
    z_acc = '0;
    v_acc = b;
    for (int i = 0; i < 128; i++) begin
      if (a[i]) begin
        z_acc = z_acc ^ v_acc;
      end
      if (v_acc[127]) begin
        v_acc = (v_acc >> 1) ^ GCM_R;
      end else begin
        v_acc = v_acc >> 1;
      end
    end
    p = z_acc;
  end

endmodule

// File: rtl/aes_gcm_tag_verify.sv
// -----------------------------------------------------------------------------
// aes_gcm_tag_verify
// Receive-side GHASH and tag checker for AES-GCM decryption. Absorbs the AAD
// and ciphertext blocks of one instance plus the lengths block, forms
// S ^ E(K,J0) and compares it with the received tag.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   i_start          : begin instance (sampled only while idle)
//   i_aad_blocks     : AAD block count, latched on start
//   i_ct_blocks      : ciphertext block count, latched on start
//   i_len_block      : len(A)||len(C) in bits, latched on start
//   i_h              : hash subkey H, latched on start
//   i_encrypted_j0   : E(K,J0), latched on start
//   i_rx_tag         : received tag, latched on start
//   i_tag_bytes      : tag length in bytes (only with AES_GCM_TAG_TRUNC_EN)
//   bus              : block stream (slave modport)
//   o_busy           : instance in progress
//   o_done           : one-cycle result strobe
//   o_tag_ok         : computed tag matches, valid with o_done, then held
//   o_tag            : computed tag, held until overwritten
//
// Build option: define AES_GCM_TAG_TRUNC_EN to compare only the leading
// i_tag_bytes bytes of the tag (legal 12..16; anything else fails).
// -----------------------------------------------------------------------------
module aes_gcm_tag_verify
  import aes_gcm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_W-1:0]     i_aad_blocks,
  input  logic [CNT_W-1:0]     i_ct_blocks,
  input  block_t               i_len_block,
  input  block_t               i_h,
  input  block_t               i_encrypted_j0,
  input  block_t               i_rx_tag,
`ifdef AES_GCM_TAG_TRUNC_EN
  input  logic [4:0]           i_tag_bytes,
`endif
  aes_gcm_tag_verify_if.slave  bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_tag_ok,
  output block_t               o_tag
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  gcm_vstate_e      state_reg;
  logic             ready_reg;
  block_t           s_reg;
  block_t           h_reg;
  block_t           len_reg;
  block_t           ej0_reg;
  block_t           rx_reg;
  logic [CNT_W-1:0] aad_n_reg;
  logic [CNT_W-1:0] ct_n_reg;
  logic [CNT_W-1:0] aad_cnt_reg;
  logic [CNT_W-1:0] ct_cnt_reg;
  logic [CNT_W-1:0] aad_cnt_next;
  logic [CNT_W-1:0] ct_cnt_next;

  logic   accept;
  block_t mul_a;
  block_t mul_p;
  block_t tag_calc;
  logic   tag_match;

  assign bus.o_ready  = ready_reg;
  assign o_busy       = (state_reg != ST_IDLE);
  // ready_reg is only ever high in AAD/CT, so it qualifies the accept.
  assign accept       = bus.i_valid && ready_reg;
  assign aad_cnt_next = aad_cnt_reg + CNT_ONE;
  assign ct_cnt_next  = ct_cnt_reg + CNT_ONE;

  // One multiplier serves both the data phases and the lengths block.
  assign mul_a = s_reg ^ ((state_reg == ST_LEN) ? len_reg : bus.i_block);

  gf128_mul u_mul (
    .a (mul_a),
    .b (h_reg),
    .p (mul_p)
  );

  assign tag_calc = s_reg ^ ej0_reg;

`ifdef AES_GCM_TAG_TRUNC_EN
  localparam block_t ALL_ONES = '1;

  logic [4:0] tag_bytes_reg;
  logic [7:0] tag_bits;
  logic       tag_len_legal;
  block_t     tag_mask;

  // Shifting toward bit 127 leaves ones only in the leading tag_bits bits
  // once inverted; 16 bytes shifts everything out and yields a full mask.
  assign tag_bits      = {tag_bytes_reg, 3'b000};
  assign tag_mask      = ~(ALL_ONES >> tag_bits);
  assign tag_len_legal = (tag_bytes_reg >= 5'd12) && (tag_bytes_reg <= 5'd16);
  assign tag_match     = tag_len_legal && (((tag_calc ^ rx_reg) & tag_mask) == '0);
`else
  assign tag_match = (tag_calc == rx_reg);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ready_reg   <= 1'b0;
      s_reg       <= '0;
      h_reg       <= '0;
      len_reg     <= '0;
      ej0_reg     <= '0;
      rx_reg      <= '0;
      aad_n_reg   <= '0;
      ct_n_reg    <= '0;
      aad_cnt_reg <= '0;
      ct_cnt_reg  <= '0;
      o_done      <= 1'b0;
      o_tag_ok    <= 1'b0;
      o_tag       <= '0;
`ifdef AES_GCM_TAG_TRUNC_EN
      tag_bytes_reg <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            h_reg       <= i_h;
            len_reg     <= i_len_block;
            ej0_reg     <= i_encrypted_j0;
            rx_reg      <= i_rx_tag;
            aad_n_reg   <= i_aad_blocks;
            ct_n_reg    <= i_ct_blocks;
            s_reg       <= '0;
            aad_cnt_reg <= '0;
            ct_cnt_reg  <= '0;
`ifdef AES_GCM_TAG_TRUNC_EN
            tag_bytes_reg <= i_tag_bytes;
`endif
            if (i_aad_blocks != CNT_ZERO) begin
              state_reg <= ST_AAD;
              ready_reg <= 1'b1;
            end else if (i_ct_blocks != CNT_ZERO) begin
              state_reg <= ST_CT;
              ready_reg <= 1'b1;
            end else begin
              state_reg <= ST_LEN;
              ready_reg <= 1'b0;
            end
          end
        end
        ST_AAD: begin
          if (accept) begin
            s_reg       <= mul_p;
            aad_cnt_reg <= aad_cnt_next;
            if (aad_cnt_next == aad_n_reg) begin
              if (ct_n_reg != CNT_ZERO) begin
                state_reg <= ST_CT;
              end else begin
                state_reg <= ST_LEN;
                ready_reg <= 1'b0;
              end
            end
          end
        end
        ST_CT: begin
          if (accept) begin
            s_reg      <= mul_p;
            ct_cnt_reg <= ct_cnt_next;
            if (ct_cnt_next == ct_n_reg) begin
              state_reg <= ST_LEN;
              ready_reg <= 1'b0;
            end
          end
        end
        ST_LEN: begin
          s_reg     <= mul_p;
          state_reg <= ST_CHECK;
        end
        ST_CHECK: begin
          o_tag     <= tag_calc;
          o_tag_ok  <= tag_match;
          o_done    <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_gcm_tag_verify.sv
// -----------------------------------------------------------------------------
// tb_aes_gcm_tag_verify
// Directed and randomized checks of aes_gcm_tag_verify against a polynomial
// (carry-less multiply + reduction) GHASH reference model.
// -----------------------------------------------------------------------------
module tb_aes_gcm_tag_verify;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         i_start        = 1'b0;
  logic [31:0]  i_aad_blocks   = '0;
  logic [31:0]  i_ct_blocks    = '0;
  logic [0:127] i_len_block    = '0;
  logic [0:127] i_h            = '0;
  logic [0:127] i_encrypted_j0 = '0;
  logic [0:127] i_rx_tag       = '0;
  logic         o_busy;
  logic         o_done;
  logic         o_tag_ok;
  logic [0:127] o_tag;
  int           tag_bytes      = 16;
`ifdef AES_GCM_TAG_TRUNC_EN
  logic [4:0]   i_tag_bytes    = 5'd16;
`endif

  aes_gcm_tag_verify_if bus();

  aes_gcm_tag_verify #(.CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_aad_blocks   (i_aad_blocks),
    .i_ct_blocks    (i_ct_blocks),
    .i_len_block    (i_len_block),
    .i_h            (i_h),
    .i_encrypted_j0 (i_encrypted_j0),
    .i_rx_tag       (i_rx_tag),
`ifdef AES_GCM_TAG_TRUNC_EN
    .i_tag_bytes    (i_tag_bytes),
`endif
    .bus            (bus),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_tag_ok       (o_tag_ok),
    .o_tag          (o_tag)
  );

  int checks = 0;
  int errors = 0;

  logic [0:127] blk [0:15];

  // results of the last run
  logic [0:127] r_tag;
  logic         r_ok;
  logic         r_done_after;
  int           r_acc;
  int           r_edge;
  int           r_last;
  int           r_ready_bad;
  logic         r_timeout;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Field multiply as polynomials: GCM bit i is the coefficient of x^i.
  function automatic logic [0:127] gmul(input logic [0:127] a, input logic [0:127] b);
    logic [127:0] pa, pb;
    logic [254:0] p;
    logic [0:127] r;
    for (int i = 0; i < 128; i++) begin
      pa[i] = a[i];
      pb[i] = b[i];
    end
    p = '0;
    for (int i = 0; i < 128; i++)
      if (pa[i]) p = p ^ ({127'd0, pb} << i);
    // x^128 == x^7 + x^2 + x + 1
    for (int i = 254; i >= 128; i--) begin
      if (p[i]) begin
        p[i]       = 1'b0;
        p[i - 128] = ~p[i - 128];
        p[i - 127] = ~p[i - 127];
        p[i - 126] = ~p[i - 126];
        p[i - 121] = ~p[i - 121];
      end
    end
    for (int i = 0; i < 128; i++) r[i] = p[i];
    return r;
  endfunction

  function automatic logic [0:127] model_tag(input int nblk, input logic [0:127] len,
                                             input logic [0:127] h, input logic [0:127] ej0);
    logic [0:127] s;
    s = '0;
    for (int j = 0; j < nblk; j++) s = gmul(s ^ blk[j], h);
    s = gmul(s ^ len, h);
    return s ^ ej0;
  endfunction

  function automatic logic model_ok(input logic [0:127] tag, input logic [0:127] rx, input int nbytes);
    if (nbytes < 12 || nbytes > 16) return 1'b0;
    for (int i = 0; i < nbytes * 8; i++)
      if (tag[i] !== rx[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Starts one instance with the currently staged inputs and streams
  // blk[0 .. na+nc-1]. Edge 0 is the edge that accepts the start.
  task automatic run(input int na, input int nc, input bit stall, input bit junk);
    int   total, idx, edge_n;
    bit   tog, v, rdy;
    total = na + nc;
    idx = 0; edge_n = 0; tog = 1'b1;
    r_acc = 0; r_last = 0; r_ready_bad = 0; r_timeout = 1'b0;
    @(negedge clk);
    i_aad_blocks = na;
    i_ct_blocks  = nc;
`ifdef AES_GCM_TAG_TRUNC_EN
    i_tag_bytes = tag_bytes[4:0];
`endif
    i_start     = 1'b1;
    bus.i_valid = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_done) break;
      if (edge_n > 300) begin
        r_timeout = 1'b1;
        break;
      end
      rdy = bus.o_ready;
      if (rdy !== (idx < total)) r_ready_bad++;
      if (o_busy !== 1'b1) r_ready_bad++;
      if (idx < total) begin
        v = stall ? tog : 1'b1;
        tog = ~tog;
        bus.i_block = blk[idx];
      end else begin
        v = junk;
        bus.i_block = rnd128();
      end
      bus.i_valid = v;
      @(posedge clk);
      edge_n++;
      if (v && rdy) begin
        r_acc++;
        r_last = edge_n;
        if (idx < total) idx++;
      end
    end
    bus.i_valid  = 1'b0;
    r_edge       = edge_n;
    r_tag        = o_tag;
    r_ok         = o_tag_ok;
    @(negedge clk);
    r_done_after = o_done;
  endtask

  task automatic check_run(input string name, input int nblk,
                           input logic [0:127] exp_tag, input logic exp_ok);
    chk({name, "_timeout"}, {127'd0, r_timeout}, 128'd0);
    chk({name, "_accepts"}, r_acc, nblk);
    chk({name, "_latency"}, r_edge, r_last + 2);
    chk({name, "_ready_busy"}, r_ready_bad, 0);
    chk({name, "_tag"}, r_tag, exp_tag);
    chk({name, "_ok"}, {127'd0, r_ok}, {127'd0, exp_ok});
    chk({name, "_done_pulse"}, {127'd0, r_done_after}, 128'd0);
  endtask

  initial begin
    logic [0:127] exp_tag;
    logic         exp_ok;
    int           na, nc;
    bit           saw_done;

    bus.i_valid = 1'b0;
    bus.i_block = '0;

    // ---------------- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {127'd0, o_busy}, 128'd0);
    chk("rst_ready", {127'd0, bus.o_ready}, 128'd0);
    chk("rst_done", {127'd0, o_done}, 128'd0);
    chk("rst_ok", {127'd0, o_tag_ok}, 128'd0);
    chk("rst_tag", o_tag, 128'd0);
    rst = 1'b0;

    // ---------------- zero key, empty message
    i_h            = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    i_encrypted_j0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    i_rx_tag       = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    i_len_block    = '0;
    run(0, 0, 1'b0, 1'b1);
    check_run("empty", 0, 128'h58e2fccefa7e3061367f1d57a4e7455a, 1'b1);
    $display("empty: tag=%h ok=%0b", r_tag, r_ok);

    // ---------------- one ciphertext block
    blk[0]      = 128'h0388dace60b6a392f328c2b971b2fe78;
    i_len_block = 128'h00000000000000000000000000000080;
    i_rx_tag    = 128'hab6e47d42cec13bdf53a67b21257bddf;
    run(0, 1, 1'b0, 1'b0);
    check_run("ct1", 1, 128'hab6e47d42cec13bdf53a67b21257bddf, 1'b1);
    $display("ct1: tag=%h ok=%0b", r_tag, r_ok);

    // ---------------- same with a flipped tag bit
    i_rx_tag = 128'hab6e47d42cec13bdf53a67b21257bdde;
    run(0, 1, 1'b0, 1'b0);
    check_run("ct1_bad", 1, 128'hab6e47d42cec13bdf53a67b21257bddf, 1'b0);
    $display("ct1_bad: tag=%h ok=%0b", r_tag, r_ok);

    // ---------------- aad=1 ct=2 with valid toggling
    i_h            = rnd128();
    i_encrypted_j0 = rnd128();
    i_len_block    = {64'd128, 64'd256};
    for (int j = 0; j < 3; j++) blk[j] = rnd128();
    exp_tag  = model_tag(3, i_len_block, i_h, i_encrypted_j0);
    i_rx_tag = exp_tag;
    run(1, 2, 1'b1, 1'b1);
    check_run("stall", 3, exp_tag, 1'b1);
    $display("stall: tag=%h ok=%0b accepts=%0d", r_tag, r_ok, r_acc);
    run(1, 2, 1'b0, 1'b0);
    check_run("nostall", 3, exp_tag, 1'b1);
    $display("nostall: tag=%h ok=%0b", r_tag, r_ok);

    // ---------------- reset in CT after one accept
    @(negedge clk);
    i_aad_blocks = 0;
    i_ct_blocks  = 3;
    i_start      = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_block = blk[0];
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("mid_busy", {127'd0, o_busy}, 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {127'd0, o_busy}, 128'd0);
    chk("arst_ready", {127'd0, bus.o_ready}, 128'd0);
    chk("arst_ok", {127'd0, o_tag_ok}, 128'd0);
    chk("arst_tag", o_tag, 128'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b0;
      if (o_done) saw_done = 1'b1;
    end
    chk("arst_no_done", {127'd0, saw_done}, 128'd0);
    $display("reset_mid: busy=%0b done_seen=%0b", o_busy, saw_done);
    run(0, 3, 1'b0, 1'b0);
    exp_tag = model_tag(3, i_len_block, i_h, i_encrypted_j0);
    check_run("after_rst", 3, exp_tag, model_ok(exp_tag, i_rx_tag, tag_bytes));
    $display("after_rst: tag=%h ok=%0b", r_tag, r_ok);

    // ---------------- randomized instances
    for (int t = 0; t < 6; t++) begin
      na = $urandom_range(0, 4);
      nc = $urandom_range(0, 4);
      i_h            = rnd128();
      i_encrypted_j0 = rnd128();
      i_len_block    = {32'd0, 32'(na * 128), 32'd0, 32'(nc * 128)};
      for (int j = 0; j < na + nc; j++) blk[j] = rnd128();
      exp_tag  = model_tag(na + nc, i_len_block, i_h, i_encrypted_j0);
      i_rx_tag = exp_tag;
      if ($urandom_range(0, 1) == 1) i_rx_tag[$urandom_range(0, 127)] ^= 1'b1;
      exp_ok = model_ok(exp_tag, i_rx_tag, tag_bytes);
      run(na, nc, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      check_run("rand", na + nc, exp_tag, exp_ok);
      $display("rand%0d: aad=%0d ct=%0d tag=%h ok=%0b", t, na, nc, r_tag, r_ok);
    end

`ifdef AES_GCM_TAG_TRUNC_EN
    // ---------------- truncated tags
    i_h            = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    i_encrypted_j0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    blk[0]         = 128'h0388dace60b6a392f328c2b971b2fe78;
    i_len_block    = 128'h00000000000000000000000000000080;
    i_rx_tag       = 128'hab6e47d42cec13bdf53a67b2deadbeef;
    tag_bytes = 12;
    run(0, 1, 1'b0, 1'b0);
    check_run("trunc12", 1, 128'hab6e47d42cec13bdf53a67b21257bddf, 1'b1);
    $display("trunc12: ok=%0b", r_ok);
    tag_bytes = 16;
    run(0, 1, 1'b0, 1'b0);
    check_run("trunc16", 1, 128'hab6e47d42cec13bdf53a67b21257bddf, 1'b0);
    $display("trunc16: ok=%0b", r_ok);
    i_rx_tag  = 128'hab6e47d42cec13bdf53a67b21257bddf;
    tag_bytes = 8;
    run(0, 1, 1'b0, 1'b0);
    check_run("trunc8", 1, 128'hab6e47d42cec13bdf53a67b21257bddf, 1'b0);
    $display("trunc8: ok=%0b", r_ok);
    tag_bytes = 16;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_gcm_tag_verify.md
Name: aes_gcm_tag_verify

Overview:
- Receive-side GHASH and tag checker for AES-GCM decryption.
- Consumes the AAD and ciphertext blocks of one instance and absorbs the lengths block.
- Forms the computed tag S ^ E(K,J0), compares it with the received tag, and reports pass/fail.
- Sits after the AES pipeline, beside the CTR decrypt path; it is the verifying end of the tag-generation stage.

Parameters:
CNT_W, 32, width of the AAD/ciphertext block counters.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
i_start  input  1  begin instance; sampled only in IDLE
i_aad_blocks  input  CNT_W  number of AAD blocks; latched on start
i_ct_blocks  input  CNT_W  number of ciphertext blocks; latched on start
i_len_block  input  [0:127]  len(A)||len(C) in bits, 64+64; latched on start
i_h  input  [0:127]  hash subkey H; latched on start
i_encrypted_j0  input  [0:127]  E(K,J0); latched on start
i_rx_tag  input  [0:127]  received tag; latched on start
i_valid  input  1  i_block valid
i_block  input  [0:127]  AAD then ciphertext, last block zero-padded by the sender
o_ready  output  1  block accepted when i_valid && o_ready
o_busy  output  1  state != IDLE
o_done  output  1  one-cycle result strobe
o_tag_ok  output  1  computed tag == received tag; valid with o_done, held until the next start
o_tag  output  [0:127]  computed tag; held until the next start

Behaviour:
- Bit 0 is the MSB, per GCM convention.
- GF(2^128) multiply uses polynomial x^128+x^7+x^2+x+1 with the reflected GCM bit order; single-cycle combinational.
- Reset values: state=IDLE, S=0, counters=0, o_ready=0, o_done=0, o_tag_ok=0, o_tag=0.
- FSM states: IDLE, AAD, CT, LEN, CHECK.
- IDLE + i_start:
  - latch all start inputs, clear S and the counters;
  - next state is AAD if aad_blocks != 0, else CT if ct_blocks != 0, else LEN.
- AAD/CT:
  - o_ready=1;
  - on accept, S <= (S ^ i_block) * H and the counter increments;
  - on the last AAD accept, go to CT, or to LEN if ct_blocks == 0;
  - on the last CT accept, go to LEN;
  - i_valid=0 stalls with no state change.
- LEN: o_ready=0; S <= (S ^ len_block) * H; go to CHECK.
- CHECK:
  - o_tag <= S ^ EJ0; o_tag_ok <= (compare); o_done <= 1; go to IDLE.
  - The compare uses combinational S ^ EJ0.
- Latency: last block accepted at edge k; LEN absorbs at k+1; o_done is high in the cycle following edge k+2.
- o_done is deasserted on the next edge.
- i_start in the same cycle as o_done is accepted, since the FSM is already in IDLE.
- i_start outside IDLE is ignored.
- i_valid outside AAD/CT is ignored.
- Counters compare as equality against the latched counts. A count of 0 skips its phase, and a counter never wraps within an instance.
- Reset mid-instance aborts immediately: o_done is never produced and all outputs return to their reset values.
- The block does no length-consistency check between the counts and i_len_block; the caller guarantees they agree.

Optional Feature:
- Macro: AES_GCM_TAG_TRUNC_EN.
- Defined:
  - Adds port i_tag_bytes (input, 5 bits), latched on start.
  - Only the leading i_tag_bytes*8 bits (bits 0..) of the tag are compared.
  - Legal values are 12..16. Any other value forces o_tag_ok=0. o_tag is always full 128 bits.
- Undefined: the port is absent and the full 128-bit compare is used.

Decomposition:
- Package aes_gcm_pkg:
  - typedef block_t (logic [0:127]);
  - GCM reduction constant R = 8'hE1 followed by 120 zeros;
  - state enum gcm_vstate_e.
- Sub-module gf128_mul (combinational, a[0:127] * b[0:127]), reusable by the encrypt-side stage.

Test Plan:
- Zero key, empty message, aad=0, ct=0, len_block=0, H=66e94bd4ef8a2c3b884cfa59ca342b2e, EJ0=rx_tag=58e2fccefa7e3061367f1d57a4e7455a -> o_done 2 cycles after start is accepted, o_tag_ok=1, o_tag=58e2fccefa7e3061367f1d57a4e7455a.
- Same H/EJ0, ct=1, block 0388dace60b6a392f328c2b971b2fe78, len_block=0...0080, rx_tag=ab6e47d42cec13bdf53a67b21257bddf -> o_tag_ok=1; o_done in the cycle after edge k+2.
- Same as the previous case with one bit of rx_tag flipped (…bdde) -> o_tag_ok=0, o_tag still ab6e47d4…bddf.
- aad=1, ct=2, i_valid toggled 1/0 every cycle -> o_ready=1 only in AAD/CT, exactly 3 accepts, result identical to a run with no stalls.
- rst pulsed while in CT after 1 accept -> no o_done; all outputs read 0; a fresh start then completes correctly.
- With AES_GCM_TAG_TRUNC_EN:
  - i_tag_bytes=12 and rx_tag low 32 bits corrupted -> o_tag_ok=1;
  - i_tag_bytes=8 -> o_tag_ok=0.
